axil_mem_fill_check: RTL and testbench

AXI4-Lite master engine for RAM bring-up and self-test. It writes an incrementing data pattern to a contiguous word range of an AXI4-Lite memory slave, reads the same range back and compares it, or does both in sequence. It sits directly upstream of the AXI4-Lite RAM slave, either on the slave port or on one arm of an interconnect. Control and status are plain sideband signals.

---
 rtl/axil_mem_fill_check_if.sv | 50 +++++
 rtl/axil_mem_fill_check.sv | 234 +++++++++++++++++++++++
 tb/tb_axil_mem_fill_check.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_mem_fill_check_if.sv
// -----------------------------------------------------------------------------
// axil_mem_fill_check_if
// AXI4-Lite bus bundle used between the fill/check engine and a RAM slave.
//   master modport : engine side (drives AW/W/AR and B/R ready)
//   slave  modport : memory side (drives AW/W/AR ready and B/R responses)
// Channels: AW (awaddr/awprot/awvalid/awready), W (wdata/wstrb/wvalid/wready),
//           B (bresp/bvalid/bready), AR (araddr/arprot/arvalid/arready),
//           R (rdata/rresp/rvalid/rready).
// -----------------------------------------------------------------------------
interface axil_mem_fill_check_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axil_mem_fill_check.sv
// -----------------------------------------------------------------------------
// axil_mem_fill_check
// AXI4-Lite master for RAM bring-up: writes an incrementing pattern
// (seed + index) over a contiguous word range, reads the range back and
// compares, or does both back to back.
// Ports:
//   i_clk, i_rst_n     : clock, asynchronous active-low reset
//   i_start            : one-cycle request, honoured only in IDLE
//   i_mode             : 01 fill, 10 check, 11 fill then check, 00 no-op
//   i_base_addr        : first byte address (word-aligned internally)
//   i_word_count       : number of words
//   i_seed             : pattern value of word 0
//   o_busy / o_done    : operation in progress / one-cycle completion pulse
//   o_err_count        : saturating compare-mismatch count
//   o_first_err_addr   : byte address of the first mismatch
//   o_resp_err         : sticky, any non-OKAY bresp/rresp seen
//   m_axil             : AXI4-Lite master bus
// -----------------------------------------------------------------------------
module axil_mem_fill_check #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 16,
  parameter int STRB_WIDTH  = DATA_WIDTH / 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic [1:0]             i_mode,
  input  logic [ADDR_WIDTH-1:0]  i_base_addr,
  input  logic [COUNT_WIDTH-1:0] i_word_count,
  input  logic [DATA_WIDTH-1:0]  i_seed,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [COUNT_WIDTH-1:0] o_err_count,
  output logic [ADDR_WIDTH-1:0]  o_first_err_addr,
  output logic                   o_resp_err,
  axil_mem_fill_check_if.master  m_axil
);
  localparam int LG_STRB = $clog2(STRB_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_RESP, S_DONE
  } state_t;

  state_t                 r_state,  w_state_next;
  logic [1:0]             r_mode,   w_mode_next;
  logic [ADDR_WIDTH-1:0]  r_base,   w_base_next;
  logic [COUNT_WIDTH-1:0] r_count,  w_count_next;
  logic [DATA_WIDTH-1:0]  r_seed,   w_seed_next;
  logic [COUNT_WIDTH-1:0] r_index,  w_index_next;
  logic                   r_aw_done, w_aw_done_next;
  logic                   r_w_done,  w_w_done_next;
  logic [COUNT_WIDTH-1:0] r_err_count, w_err_count_next;
  logic [ADDR_WIDTH-1:0]  r_first_err_addr, w_first_err_addr_next;
  logic                   r_resp_err, w_resp_err_next;

  logic [ADDR_WIDTH-1:0]  w_addr;
  logic [DATA_WIDTH-1:0]  w_pattern;
  logic                   w_last;
  logic                   w_awvalid;
  logic                   w_wvalid;
  logic                   w_aw_hs;
  logic                   w_w_hs;
  logic [STRB_WIDTH-1:0]  w_wstrb;

  // Address and pattern are derived from the index, so both wrap naturally
  // at their own widths.
  assign w_addr    = r_base + (ADDR_WIDTH'(r_index) << LG_STRB);
  assign w_pattern = r_seed + DATA_WIDTH'(r_index);
  assign w_last    = (r_index == r_count - COUNT_WIDTH'(1));

  // Each write channel retires independently; a done flag keeps its valid low
  // for the rest of the word.
  assign w_awvalid = (r_state == S_WR_REQ) && !r_aw_done;
  assign w_wvalid  = (r_state == S_WR_REQ) && !r_w_done;
  assign w_aw_hs   = w_awvalid && m_axil.awready;
  assign w_w_hs    = w_wvalid && m_axil.wready;

  // Full-word writes only.
  for (genvar gi = 0; gi < STRB_WIDTH; gi++) begin : g_strb
    assign w_wstrb[gi] = 1'b1;
  end

  assign m_axil.awaddr  = w_addr;
  assign m_axil.awprot  = 3'b000;
  assign m_axil.awvalid = w_awvalid;
  assign m_axil.wdata   = w_pattern;
  assign m_axil.wstrb   = w_wstrb;
  assign m_axil.wvalid  = w_wvalid;
  assign m_axil.bready  = (r_state == S_WR_RESP);
  assign m_axil.araddr  = w_addr;
  assign m_axil.arprot  = 3'b000;
  assign m_axil.arvalid = (r_state == S_RD_REQ);
  assign m_axil.rready  = (r_state == S_RD_RESP);

  assign o_busy           = (r_state != S_IDLE) && (r_state != S_DONE);
  assign o_done           = (r_state == S_DONE);
  assign o_err_count      = r_err_count;
  assign o_first_err_addr = r_first_err_addr;
  assign o_resp_err       = r_resp_err;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state          <= S_IDLE;
      r_mode           <= 2'b00;
      r_base           <= '0;
      r_count          <= '0;
      r_seed           <= '0;
      r_index          <= '0;
      r_aw_done        <= 1'b0;
      r_w_done         <= 1'b0;
      r_err_count      <= '0;
      r_first_err_addr <= '0;
      r_resp_err       <= 1'b0;
    end else begin
      r_state          <= w_state_next;
      r_mode           <= w_mode_next;
      r_base           <= w_base_next;
      r_count          <= w_count_next;
      r_seed           <= w_seed_next;
      r_index          <= w_index_next;
      r_aw_done        <= w_aw_done_next;
      r_w_done         <= w_w_done_next;
      r_err_count      <= w_err_count_next;
      r_first_err_addr <= w_first_err_addr_next;
      r_resp_err       <= w_resp_err_next;
    end
  end

  always_comb begin
    w_state_next          = r_state;
    w_mode_next           = r_mode;
    w_base_next           = r_base;
    w_count_next          = r_count;
    w_seed_next           = r_seed;
    w_index_next          = r_index;
    w_aw_done_next        = r_aw_done;
    w_w_done_next         = r_w_done;
    w_err_count_next      = r_err_count;
    w_first_err_addr_next = r_first_err_addr;
    w_resp_err_next       = r_resp_err;

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_mode_next           = i_mode;
          w_base_next           = i_base_addr & ~ADDR_WIDTH'(STRB_WIDTH - 1);
          w_count_next          = i_word_count;
          w_seed_next           = i_seed;
          w_index_next          = '0;
          w_aw_done_next        = 1'b0;
          w_w_done_next         = 1'b0;
          w_err_count_next      = '0;
          w_first_err_addr_next = '0;
          w_resp_err_next       = 1'b0;
          if (i_word_count == '0 || i_mode == 2'b00) begin
            w_state_next = S_DONE;
          end else if (i_mode[0]) begin
            w_state_next = S_WR_REQ;
          end else begin
            w_state_next = S_RD_REQ;
          end
        end
      end

      S_WR_REQ: begin
        w_aw_done_next = r_aw_done | w_aw_hs;
        w_w_done_next  = r_w_done | w_w_hs;
        if (w_aw_done_next && w_w_done_next) begin
          w_state_next = S_WR_RESP;
        end
      end

      S_WR_RESP: begin
        if (m_axil.bvalid) begin
          if (m_axil.bresp != 2'b00) begin
            w_resp_err_next = 1'b1;
          end
          if (w_last) begin
            if (r_mode[1]) begin
              w_index_next = '0;
              w_state_next = S_RD_REQ;
            end else begin
              w_state_next = S_DONE;
            end
          end else begin
            w_index_next   = r_index + COUNT_WIDTH'(1);
            w_aw_done_next = 1'b0;
            w_w_done_next  = 1'b0;
            w_state_next   = S_WR_REQ;
          end
        end
      end

      S_RD_REQ: begin
        if (m_axil.arready) begin
          w_state_next = S_RD_RESP;
        end
      end

      S_RD_RESP: begin
        if (m_axil.rvalid) begin
          if (m_axil.rresp != 2'b00) begin
            w_resp_err_next = 1'b1;
          end
          if (m_axil.rdata != w_pattern) begin
            // The count saturates and never returns to zero within a run, so
            // zero identifies the first mismatch.
            if (r_err_count == '0) begin
              w_first_err_addr_next = w_addr;
            end
            if (r_err_count != '1) begin
              w_err_count_next = r_err_count + COUNT_WIDTH'(1);
            end
          end
          if (w_last) begin
            w_state_next = S_DONE;
          end else begin
            w_index_next = r_index + COUNT_WIDTH'(1);
            w_state_next = S_RD_REQ;
          end
        end
      end

      S_DONE: begin
        w_state_next = S_IDLE;
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_axil_mem_fill_check.sv
// -----------------------------------------------------------------------------
// tb_axil_mem_fill_check
// Drives the engine against a behavioural AXI4-Lite RAM with adjustable
// ready latencies and optional SLVERR injection, and compares every bus
// transaction and status output with a word-list reference model.
// -----------------------------------------------------------------------------
module tb_axil_mem_fill_check;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [15:0] base_addr = '0;
  logic [15:0] word_count = '0;
  logic [31:0] seed = '0;
  logic        busy, done, resp_err;
  logic [15:0] err_count, first_err_addr;

  int tests = 0;
  int fails = 0;

  axil_mem_fill_check_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) bus ();

  axil_mem_fill_check #(
    .DATA_WIDTH(32), .ADDR_WIDTH(16), .COUNT_WIDTH(16)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_mode(mode),
    .i_base_addr(base_addr), .i_word_count(word_count), .i_seed(seed),
    .o_busy(busy), .o_done(done), .o_err_count(err_count),
    .o_first_err_addr(first_err_addr), .o_resp_err(resp_err),
    .m_axil(bus.master)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural RAM slave ----------------
  logic [31:0] mem [16384];
  int          aw_lat = 0, w_lat = 0, ar_lat = 0;
  int          inj_b = -1;
  int          b_num = 0;
  int          aw_cnt, w_cnt, ar_cnt;
  logic        aw_got, w_got;
  logic [15:0] aw_a;
  logic [31:0] w_d;
  logic        bd_tog = 1'b0, bd_seen = 1'b0;
  logic [15:0] bd_addr = '0;
  logic [31:0] bd_data = '0;

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = '0;
  end

  assign bus.awready = bus.awvalid && !aw_got && (aw_cnt >= aw_lat);
  assign bus.wready  = bus.wvalid && !w_got && (w_cnt >= w_lat);
  assign bus.arready = bus.arvalid && !bus.rvalid && (ar_cnt >= ar_lat);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0;
      bus.bvalid <= 1'b0; bus.bresp <= 2'b00;
      bus.rvalid <= 1'b0; bus.rresp <= 2'b00; bus.rdata <= '0;
    end else begin
      if (bd_tog != bd_seen) begin
        mem[bd_addr[15:2]] <= bd_data;
        bd_seen <= bd_tog;
      end
      if (bus.awvalid && bus.awready) begin
        aw_a <= bus.awaddr; aw_got <= 1'b1; aw_cnt <= 0;
      end else if (bus.awvalid && !aw_got) begin
        aw_cnt <= aw_cnt + 1;
      end
      if (bus.wvalid && bus.wready) begin
        w_d <= bus.wdata; w_got <= 1'b1; w_cnt <= 0;
      end else if (bus.wvalid && !w_got) begin
        w_cnt <= w_cnt + 1;
      end
      if (aw_got && w_got && !bus.bvalid) begin
        mem[aw_a[15:2]] <= w_d;
        bus.bvalid <= 1'b1;
        bus.bresp  <= (b_num == inj_b) ? 2'b10 : 2'b00;
        b_num      <= b_num + 1;
        aw_got <= 1'b0; w_got <= 1'b0;
      end
      if (bus.bvalid && bus.bready) bus.bvalid <= 1'b0;
      if (bus.arvalid && bus.arready) begin
        bus.rvalid <= 1'b1; bus.rresp <= 2'b00;
        bus.rdata  <= mem[bus.araddr[15:2]];
        ar_cnt     <= 0;
      end else if (bus.arvalid) begin
        ar_cnt <= ar_cnt + 1;
      end
      if (bus.rvalid && bus.rready) bus.rvalid <= 1'b0;
    end
  end

  // ---------------- bus monitor ----------------
  logic [15:0] aw_log [4096];
  logic [31:0] w_log  [4096];
  logic [15:0] ar_log [4096];
  int aw_n = 0, w_n = 0, ar_n = 0, done_n = 0, valid_n = 0, strb_bad = 0, viol = 0;
  int cyc = 0, last_hs = 0, done_cyc = 0;
  logic aw_pend_q = 1'b0, w_pend_q = 1'b0, ar_pend_q = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.awvalid && bus.awready) begin aw_log[aw_n] <= bus.awaddr; aw_n <= aw_n + 1; end
    if (bus.wvalid && bus.wready) begin
      w_log[w_n] <= bus.wdata; w_n <= w_n + 1;
      if (bus.wstrb != 4'hF) strb_bad <= strb_bad + 1;
    end
    if (bus.arvalid && bus.arready) begin ar_log[ar_n] <= bus.araddr; ar_n <= ar_n + 1; end
    if ((bus.bvalid && bus.bready) || (bus.rvalid && bus.rready)) last_hs <= cyc;
    if (done) begin done_n <= done_n + 1; done_cyc <= cyc; end
    if (bus.awvalid || bus.wvalid || bus.arvalid) valid_n <= valid_n + 1;
    if (rst_n) begin
      if ((aw_pend_q && !bus.awvalid) || (w_pend_q && !bus.wvalid) ||
          (ar_pend_q && !bus.arvalid)) viol <= viol + 1;
    end
    aw_pend_q <= rst_n && bus.awvalid && !bus.awready;
    w_pend_q  <= rst_n && bus.wvalid && !bus.wready;
    ar_pend_q <= rst_n && bus.arvalid && !bus.arready;
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [16384];
  logic [15:0] exp_aw [$];
  logic [31:0] exp_w  [$];
  logic [15:0] exp_ar [$];
  int          exp_err;
  logic [15:0] exp_first;

  initial begin
    for (int i = 0; i < 16384; i++) ref_mem[i] = '0;
  end

  // Word i lives at base + 4*i and holds seed + i; a check compares memory
  // contents against that rule.
  task automatic model_run(input logic [1:0] m, input logic [15:0] b,
                           input logic [15:0] c, input logic [31:0] s);
    logic [15:0] a;
    logic [15:0] ab;
    exp_aw.delete(); exp_w.delete(); exp_ar.delete();
    exp_err = 0; exp_first = '0;
    ab = b & 16'hFFFC;
    if (c == 0 || m == 2'b00) return;
    if (m[0]) begin
      for (int i = 0; i < int'(c); i++) begin
        a = ab + 16'(i * 4);
        exp_aw.push_back(a);
        exp_w.push_back(s + 32'(i));
        ref_mem[a[15:2]] = s + 32'(i);
      end
    end
    if (m[1]) begin
      for (int i = 0; i < int'(c); i++) begin
        a = ab + 16'(i * 4);
        exp_ar.push_back(a);
        if (ref_mem[a[15:2]] != s + 32'(i)) begin
          if (exp_err == 0) exp_first = a;
          exp_err++;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic backdoor(input logic [15:0] a, input logic [31:0] d);
    bd_addr = a; bd_data = d; bd_tog = ~bd_tog;
    ref_mem[a[15:2]] = d;
    repeat (2) @(negedge clk);
  endtask

  task automatic run_op(input logic [1:0] m, input logic [15:0] b, input logic [15:0] c,
                        input logic [31:0] s, input int mid_start, input logic exp_resp);
    int aw0, w0, ar0, d0, v0, sb0, vi0;
    bit seen, immediate;
    model_run(m, b, c, s);
    aw0 = aw_n; w0 = w_n; ar0 = ar_n; d0 = done_n; v0 = valid_n; sb0 = strb_bad; vi0 = viol;
    immediate = (c == 0) || (m == 2'b00);
    @(negedge clk);
    mode = m; base_addr = b; word_count = c; seed = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (immediate) begin
      chk("imm_done", done, 1);
      chk("imm_busy", busy, 0);
    end else begin
      chk("first_awvalid", bus.awvalid, m[0]);
      chk("first_wvalid", bus.wvalid, m[0]);
      chk("first_arvalid", bus.arvalid, !m[0]);
      chk("busy_run", busy, 1);
    end
    seen = 0;
    for (int k = 0; k < 4000 && !seen; k++) begin
      if (done_n != d0) begin
        seen = 1;
      end else begin
        if (k == mid_start) begin
          start = 1'b1; mode = 2'b11; word_count = 16'd1; seed = ~s; base_addr = b + 16'h40;
        end
        @(negedge clk);
        start = 1'b0;
      end
    end
    chk("done_seen", seen, 1);
    repeat (3) @(negedge clk);
    chk("done_pulses", done_n - d0, 1);
    if (immediate) chk("no_valids", valid_n - v0, 0);
    else chk("done_latency", done_cyc, last_hs + 1);
    chk("aw_count", aw_n - aw0, exp_aw.size());
    chk("w_count", w_n - w0, exp_w.size());
    chk("ar_count", ar_n - ar0, exp_ar.size());
    for (int i = 0; i < exp_aw.size() && i < aw_n - aw0; i++) chk("awaddr", aw_log[aw0 + i], exp_aw[i]);
    for (int i = 0; i < exp_w.size() && i < w_n - w0; i++) chk("wdata", w_log[w0 + i], exp_w[i]);
    for (int i = 0; i < exp_ar.size() && i < ar_n - ar0; i++) chk("araddr", ar_log[ar0 + i], exp_ar[i]);
    chk("wstrb", strb_bad - sb0, 0);
    chk("valid_held", viol - vi0, 0);
    chk("err_count", err_count, exp_err);
    chk("first_err_addr", first_err_addr, exp_first);
    chk("resp_err", resp_err, exp_resp);
    chk("busy_after", busy, 0);
    $display("[TB] op mode=%0b base=0x%04h count=%0d seed=0x%08h err=%0d first=0x%04h resp_err=%0b",
             m, b, c, s, err_count, first_err_addr, resp_err);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    logic [1:0]  rm;
    logic [15:0] rb, rc;
    logic [31:0] rs;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_awvalid", bus.awvalid, 0);
    chk("rst_wvalid", bus.wvalid, 0);
    chk("rst_arvalid", bus.arvalid, 0);
    chk("rst_bready", bus.bready, 0);
    chk("rst_rready", bus.rready, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_first_err", first_err_addr, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_awprot", bus.awprot, 0);
    chk("rst_arprot", bus.arprot, 0);
    chk("rst_wstrb", bus.wstrb, 4'hF);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Plain fill
    run_op(2'b01, 16'h0100, 16'd4, 32'h000000A0, -1, 1'b0);
    // Fill then check with wrapping pattern and some ready latency
    aw_lat = 1; w_lat = 2; ar_lat = 1;
    run_op(2'b11, 16'h0200, 16'd8, 32'hFFFFFFFE, -1, 1'b0);
    aw_lat = 0; w_lat = 0; ar_lat = 0;
    // Check after corrupting two words of the first fill
    backdoor(16'h0108, 32'h0000DEAD);
    backdoor(16'h010C, 32'h00000000);
    run_op(2'b10, 16'h0100, 16'd4, 32'h000000A0, -1, 1'b0);
    // Address wrap, unaligned base low bits ignored
    run_op(2'b11, 16'hFFFA, 16'd4, $urandom, -1, 1'b0);
    // Count 0 and mode 00 complete at once with no bus activity
    run_op(2'b11, 16'h0300, 16'd0, 32'h12345678, -1, 1'b0);
    run_op(2'b00, 16'h0300, 16'd5, 32'h12345678, -1, 1'b0);
    // awready three cycles behind wready
    aw_lat = 3; w_lat = 0;
    run_op(2'b01, 16'h0400, 16'd4, 32'h00C0FFEE, -1, 1'b0);
    aw_lat = 0;
    // SLVERR on the second B of the run
    inj_b = b_num + 1;
    run_op(2'b11, 16'h0500, 16'd3, 32'h55AA0000, -1, 1'b1);
    inj_b = -1;
    // start pulsed mid-run is ignored
    aw_lat = 2; w_lat = 1; ar_lat = 2;
    run_op(2'b11, 16'h0600, 16'd6, 32'h31415926, 3, 1'b0);
    // Reset while awvalid is pending
    aw_lat = 50; w_lat = 0;
    @(negedge clk);
    mode = 2'b01; base_addr = 16'h0700; word_count = 16'd2; seed = 32'h1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_awvalid", bus.awvalid, 1);
    d0 = done_n;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_awvalid", bus.awvalid, 0);
    chk("mid_rst_wvalid", bus.wvalid, 0);
    chk("mid_rst_arvalid", bus.arvalid, 0);
    chk("mid_rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_rst_no_done", done_n - d0, 0);
    chk("mid_rst_idle", busy, 0);
    aw_lat = 0;

    // Randomized runs, sometimes with a corrupted word inside the range
    for (int r = 0; r < 8; r++) begin
      aw_lat = $urandom_range(0, 3); w_lat = $urandom_range(0, 3); ar_lat = $urandom_range(0, 3);
      rm = 2'($urandom_range(1, 3));
      rb = 16'($urandom);
      rc = 16'($urandom_range(1, 10));
      rs = $urandom;
      if ($urandom_range(0, 1) == 1)
        backdoor((rb & 16'hFFFC) + 16'(4 * $urandom_range(0, int'(rc) - 1)), $urandom);
      run_op(rm, rb, rc, rs, -1, 1'b0);
      if (rm == 2'b01)
        run_op(2'b10, rb, rc, rs, -1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
